ex_forward_pipe: RTL
====================

Name: ex_forward_pipe

Overview:
- Consumer end of the hazard-control interface: takes the load-use stall and the four forwarding flags and acts on them.
- Holds the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage core.
- Inserts a bubble on stall and drives the forwarded EX operands.
- Sits between the decode/register-file read logic and the ALU, data memory and register-file write port.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating stall and forward event counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_rs1_data  in  XLEN  register-file read data for rs1
- id_rs2_data  in  XLEN  register-file read data for rs2
- id_rd  in  5  destination register of the ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- stall  in  1  load-use hazard on the ID instruction
- fwd_ex_ex1  in  1  op1 of the EX instruction comes from the EX/MEM result
- fwd_ex_ex2  in  1  op2 of the EX instruction comes from the EX/MEM result
- fwd_mem_ex1  in  1  op1 of the EX instruction comes from the MEM/WB result
- fwd_mem_ex2  in  1  op2 of the EX instruction comes from the MEM/WB result
- alu_result  in  XLEN  combinational ALU output for the EX instruction
- mem_rdata  in  XLEN  data-memory read data for the MEM instruction
- id_hold  out  1  freeze PC and IF/ID
- ex_op1  out  XLEN  forwarded ALU operand 1
- ex_op2  out  XLEN  forwarded ALU operand 2
- ex_valid  out  1  EX holds a real instruction
- mem_addr  out  XLEN  EX/MEM ALU result, used as the memory address
- wb_we  out  1  register-file write enable
- wb_rd  out  5  register-file write index
- wb_data  out  XLEN  register-file write data
- stall_cnt  out  CNT_W  cycles with a bubble inserted
- fwd_cnt  out  CNT_W  cycles with any forward taken

Behaviour:
- Reset (rst=0 at posedge): every pipeline register goes to 0, including valid, regwrite, is_load, rd and data fields. Both counters go to 0.
- Reset outputs: id_hold=0, ex_valid=0, wb_we=0, wb_rd=0, wb_data=0, ex_op1=0, ex_op2=0, mem_addr=0.
- Reset has priority over stall and all flags, including mid-stall and mid-forward.
- ID/EX update, each posedge:
  - stall=1: load a bubble (valid=0, regwrite=0, is_load=0, rd=0, data=0).
  - stall=0: load the id_* inputs.
- id_hold = stall, combinational and same cycle. The block does not drive any IF/ID register itself.
- EX/MEM update, each posedge, unconditionally: alu_result, rd, regwrite and is_load from ID/EX; valid = ex_valid.
- MEM/WB update, each posedge, unconditionally:
  - data = mem_rdata if EX/MEM is_load, else the EX/MEM ALU result.
  - rd and regwrite copied from EX/MEM; valid copied from EX/MEM valid.
- Write-back outputs:
  - wb_we = MEM/WB valid & regwrite & (rd != 0). A write to x0 is never emitted.
  - wb_rd and wb_data come from MEM/WB.
- Flag timing: all four forwarding flags refer to the instruction currently in ID/EX and are sampled in the same cycle.
- Operand mux, combinational, ex_op1 (ex_op2 identical with the *2 flags):
  - fwd_ex_ex1=1: EX/MEM ALU result.
  - else fwd_mem_ex1=1: MEM/WB data.
  - else: ID/EX rs1 data.
  - EX-EX has priority when both flags are set (the newer producer wins).
- Flags are honoured even when ID/EX valid=0; the ALU result is then discarded downstream.
- Latency: 1 cycle ID to EX, 3 cycles ID to write-back. Each stall adds exactly 1 bubble.
- Back-to-back stalls: each stall cycle inserts another bubble and id_hold stays high.
- stall_cnt: +1 on each posedge with stall=1 and rst=1. Saturates at 2^CNT_W-1, no wrap.
- fwd_cnt: +1 on each posedge where any of the four flags is 1. Saturates at 2^CNT_W-1, no wrap.
- No other state. Inputs with X while id_valid=0 must not propagate into wb_we.

Test Plan:
- Reset mid-stream: stall=1 and rd=5 in flight, rst=0 for one cycle -> next cycle all outputs 0, wb_we=0, counters 0.
- Plain ALU chain: ID instruction with rs1 data=7, rs2 data=3, rd=4, no flags, alu_result=10 -> ex_op1=7 and ex_op2=3 after 1 cycle; wb_we=1, wb_rd=4, wb_data=10 3 cycles after issue.
- EX-EX forward: EX/MEM result=0x55, ID/EX rs1 data=0x11, fwd_ex_ex1=1 -> ex_op1=0x55 that cycle and fwd_cnt increments by 1.
- Both flags on op2: fwd_ex_ex2=1 and fwd_mem_ex2=1, EX/MEM result=0xA, MEM/WB data=0xB -> ex_op2=0xA.
- Load-use: load rd=6 with mem_rdata=0xDEAD, stall=1 for 1 cycle -> id_hold=1, the following cycle ex_valid=0, stall_cnt=1. With fwd_mem_ex1=1 two cycles later -> ex_op1=0xDEAD.
- x0 and saturation: write with rd=0 -> wb_we stays 0. With CNT_W=2, stall held for 5 cycles -> stall_cnt=3.

Source files
------------

// File: rtl/ex_forward_pipe.sv
// ---------------------------------------------------------------------------
// ex_forward_pipe
//
// Holds the ID/EX, EX/MEM and MEM/WB pipeline registers of a 5-stage core
// and acts on the hazard-control outputs. A load-use stall turns the next
// ID/EX load into a bubble and freezes the front end. The four forwarding
// flags select the EX operands from the older in-flight results.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   id_*                  decoded ID-stage instruction and register-file reads
//   stall                 load-use hazard: insert a bubble into ID/EX
//   fwd_ex_ex1/2          take EX operand 1/2 from the EX/MEM ALU result
//   fwd_mem_ex1/2         take EX operand 1/2 from the MEM/WB write-back data
//   alu_result            ALU output for the instruction in EX
//   mem_rdata             data-memory read data for the instruction in MEM
//   id_hold               freeze PC and IF/ID (equals stall)
//   ex_op1, ex_op2        forwarded ALU operands
//   ex_valid              EX holds a real instruction
//   mem_addr              EX/MEM ALU result, used as the memory address
//   wb_we, wb_rd, wb_data register-file write port
//   stall_cnt, fwd_cnt    saturating bubble / forward event counters
// ---------------------------------------------------------------------------
module ex_forward_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             stall,
    input  logic             fwd_ex_ex1,
    input  logic             fwd_ex_ex2,
    input  logic             fwd_mem_ex1,
    input  logic             fwd_mem_ex2,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             id_hold,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic             ex_valid,
    output logic [XLEN-1:0]  mem_addr,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            is_load;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            is_load;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } memwb_t;

    idex_t            idex_q,  idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
    logic             fwd_any;

    assign fwd_any = fwd_ex_ex1 | fwd_ex_ex2 | fwd_mem_ex1 | fwd_mem_ex2;

    // Next-state for all three pipeline registers and both counters.
    always_comb begin
        // NOTE: every field gets a default before any branch, so no latch is inferred.
        idex_d      = '0;   // default is the bubble
        exmem_d     = '0;
        memwb_d     = '0;
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;

        if (!stall) begin
            idex_d.valid    = id_valid;
            idex_d.regwrite = id_regwrite;
            idex_d.is_load  = id_is_load;
            idex_d.rd       = id_rd;
            idex_d.rs1      = id_rs1_data;
            idex_d.rs2      = id_rs2_data;
        end

        exmem_d.valid    = idex_q.valid;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.is_load  = idex_q.is_load;
        exmem_d.rd       = idex_q.rd;
        exmem_d.alu      = alu_result;

        memwb_d.valid    = exmem_q.valid;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.rd       = exmem_q.rd;
        memwb_d.data     = exmem_q.is_load ? mem_rdata : exmem_q.alu;

        // Counters hold at all-ones instead of wrapping.
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (fwd_any && (fwd_cnt_q != CNT_MAX)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    // Reset wins over stall and every forwarding flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    // Operand muxes: the EX/MEM result is the newer producer, so it wins
    // when both flags are set. Flags are honoured even for a bubble in EX.
    always_comb begin
        ex_op1 = idex_q.rs1;
        ex_op2 = idex_q.rs2;
        if (fwd_ex_ex1) begin
            ex_op1 = exmem_q.alu;
        end else if (fwd_mem_ex1) begin
            ex_op1 = memwb_q.data;
        end
        if (fwd_ex_ex2) begin
            ex_op2 = exmem_q.alu;
        end else if (fwd_mem_ex2) begin
            ex_op2 = memwb_q.data;
        end
    end

    assign id_hold   = stall;
    assign ex_valid  = idex_q.valid;
    assign mem_addr  = exmem_q.alu;
    // x0 is hard-wired zero, so a write to it is suppressed here.
    assign wb_we     = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != 5'd0);
    assign wb_rd     = memwb_q.rd;
    assign wb_data   = memwb_q.data;
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule
